// File: rtl/vram_slot_responder_pkg.sv
// Shared types and lane helpers for the VDP VRAM slot responder.
// Holds the FSM state type, write-size encodings and byte-enable helper.
package vdp_vram_pkg;

  typedef enum logic [1:0] {
    VS_IDLE    = 2'd0,
    VS_ISSUE   = 2'd1,
    VS_WAIT_RD = 2'd2
  } vs_state_t;

  localparam logic [1:0] WR_SIZE_8  = 2'b00;
  localparam logic [1:0] WR_SIZE_16 = 2'b01;
  localparam logic [1:0] WR_SIZE_32 = 2'b10;

  // The reserved size 2'b11 falls into the byte case.
  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      WR_SIZE_16: be_for = addr_lo[1] ? 4'b1100 : 4'b0011;
      WR_SIZE_32: be_for = 4'b1111;
      default:    be_for = 4'b0001 << addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/vram_lane_pack.sv
// Combinational lane mapping between slot-sized data and the 32-bit VRAM word,
// in both directions: write packing (be/wdata) and read byte/half selection.
module vram_lane_pack
  import vdp_vram_pkg::*;
(
  input  logic        is_write,
  input  logic [1:0]  size,
  input  logic [1:0]  wr_lo,
  input  logic [7:0]  d8,
  input  logic [15:0] d16,
  input  logic [31:0] d32,
  input  logic [1:0]  rd_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [7:0]  rd8,
  output logic [15:0] rd16
);

  always_comb begin
    be    = 4'b1111;
    wdata = 32'h0;
    if (is_write) begin
      be = be_for(size, wr_lo);
      case (size)
        WR_SIZE_16: wdata = {2{d16}};
        WR_SIZE_32: wdata = d32;
        default:    wdata = {4{d8}};
      endcase
    end
  end

  assign rd16 = rd_lo[1] ? rdata[31:16] : rdata[15:0];
  assign rd8  = rdata[{rd_lo, 3'b000} +: 8];

endmodule

// File: rtl/vram_slot_responder.sv
// Memory-side end of the VDP VRAM slot interface: captures one arbiter slot per
// sample point and turns it into a single 32-bit word access on the backend port.
module vram_slot_responder
  import vdp_vram_pkg::*;
#(
  parameter int MEM_AW  = 17,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK21M,
  input  logic              RESET,
  input  logic [1:0]        DOTSTATE,
  input  logic [18:0]       IRAMADR,
  input  logic              PRAMWE_N,
  input  logic [1:0]        PRAM_WR_SIZE,
  input  logic [7:0]        PRAMDBO_8,
  input  logic [15:0]       PRAMDBO_16,
  input  logic [31:0]       PRAMDBO_32,
  output logic [7:0]        PRAMDAT_8,
  output logic [15:0]       PRAMDAT_16,
  output logic [31:0]       PRAMDAT_32,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              overrun
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  vs_state_t state_q, state_d;

  logic [1:0]        dot_prev_q, dot_prev_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              overrun_q, overrun_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [1:0]        lat_lo_q, lat_lo_d;
  logic [31:0]       pramdat_32_q, pramdat_32_d;
  logic [15:0]       pramdat_16_q, pramdat_16_d;
  logic [7:0]        pramdat_8_q, pramdat_8_d;

  logic        sample_pt;
  logic        tmo_hit;
  logic        wr_done;
  logic        rd_done;
  logic        abandon;
  logic        slot_free;
  logic        accept;
  logic        drop;
  logic [3:0]  pack_be;
  logic [31:0] pack_wdata;
  logic [7:0]  sel_8;
  logic [15:0] sel_16;

  vram_lane_pack u_lane_pack (
    .is_write (~PRAMWE_N),
    .size     (PRAM_WR_SIZE),
    .wr_lo    (IRAMADR[1:0]),
    .d8       (PRAMDBO_8),
    .d16      (PRAMDBO_16),
    .d32      (PRAMDBO_32),
    .rd_lo    (lat_lo_q),
    .rdata    (mem_rdata),
    .be       (pack_be),
    .wdata    (pack_wdata),
    .rd8      (sel_8),
    .rd16     (sel_16)
  );

  // A sample point is the first cycle DOTSTATE enters 00 or 11, so a held phase captures once.
  assign sample_pt = ((DOTSTATE == 2'b00) || (DOTSTATE == 2'b11)) && (DOTSTATE != dot_prev_q);
  assign tmo_hit   = (tmo_q >= TMO_LAST);
  assign wr_done   = (state_q == VS_ISSUE) && mem_ack && mem_we_q;
  assign rd_done   = (state_q == VS_WAIT_RD) && mem_rvalid;
  assign abandon   = tmo_hit && (((state_q == VS_ISSUE) && !mem_ack) ||
                                 ((state_q == VS_WAIT_RD) && !mem_rvalid));
  // The cycle that finishes an access can already take the next slot.
  assign slot_free = (state_q == VS_IDLE) || wr_done || rd_done || abandon;
  assign accept    = sample_pt && slot_free;
  assign drop      = sample_pt && !slot_free;

  always_ff @(posedge CLK21M) begin
    if (RESET) begin
      state_q <= VS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      VS_ISSUE: begin
        if (mem_ack) begin
          state_d = mem_we_q ? VS_IDLE : VS_WAIT_RD;
        end else if (tmo_hit) begin
          state_d = VS_IDLE;
        end
      end
      VS_WAIT_RD: begin
        if (mem_rvalid || tmo_hit) begin
          state_d = VS_IDLE;
        end
      end
      default: state_d = state_q;
    endcase
    if (accept) begin
      state_d = VS_ISSUE;
    end
  end

  always_comb begin
    dot_prev_d   = DOTSTATE;
    tmo_d        = tmo_q;
    overrun_d    = overrun_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    lat_lo_d     = lat_lo_q;
    pramdat_32_d = pramdat_32_q;
    pramdat_16_d = pramdat_16_q;
    pramdat_8_d  = pramdat_8_q;

    if (state_q == VS_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end

    if ((state_q == VS_ISSUE) && (mem_ack || tmo_hit)) begin
      mem_req_d = 1'b0;
    end

    if (rd_done) begin
      pramdat_32_d = mem_rdata;
      pramdat_16_d = sel_16;
      pramdat_8_d  = sel_8;
    end

    if (abandon || drop) begin
      overrun_d = 1'b1;
    end

    if (accept) begin
      tmo_d       = '0;
      mem_req_d   = 1'b1;
      mem_we_d    = ~PRAMWE_N;
      mem_addr_d  = MEM_AW'(IRAMADR[18:2]);
      mem_wdata_d = pack_wdata;
      mem_be_d    = pack_be;
      lat_lo_d    = IRAMADR[1:0];
    end
  end

  always_ff @(posedge CLK21M) begin
    if (RESET) begin
      dot_prev_q   <= 2'b10;
      tmo_q        <= '0;
      overrun_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_be_q     <= 4'h0;
      lat_lo_q     <= 2'b00;
      pramdat_32_q <= 32'h0;
      pramdat_16_q <= 16'h0;
      pramdat_8_q  <= 8'h0;
    end else begin
      dot_prev_q   <= dot_prev_d;
      tmo_q        <= tmo_d;
      overrun_q    <= overrun_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      lat_lo_q     <= lat_lo_d;
      pramdat_32_q <= pramdat_32_d;
      pramdat_16_q <= pramdat_16_d;
      pramdat_8_q  <= pramdat_8_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign overrun    = overrun_q;
  assign PRAMDAT_32 = pramdat_32_q;
  assign PRAMDAT_16 = pramdat_16_q;
  assign PRAMDAT_8  = pramdat_8_q;

endmodule

// File: tb/tb_vram_slot_responder.sv
// Bench for vram_slot_responder: directed slot scenarios followed by randomized
// slots, with a transaction-level model acting as the backend memory.
module tb_vram_slot_responder;

  localparam int MEM_AW  = 17;
  localparam int TIMEOUT = 15;

  logic              CLK21M = 1'b0;
  logic              RESET;
  logic [1:0]        DOTSTATE;
  logic [18:0]       IRAMADR;
  logic              PRAMWE_N;
  logic [1:0]        PRAM_WR_SIZE;
  logic [7:0]        PRAMDBO_8;
  logic [15:0]       PRAMDBO_16;
  logic [31:0]       PRAMDBO_32;
  logic [7:0]        PRAMDAT_8;
  logic [15:0]       PRAMDAT_16;
  logic [31:0]       PRAMDAT_32;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              mem_rvalid;
  logic              overrun;

  always #5 CLK21M = ~CLK21M;

  vram_slot_responder #(.MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT)) dut (
    .CLK21M       (CLK21M),
    .RESET        (RESET),
    .DOTSTATE     (DOTSTATE),
    .IRAMADR      (IRAMADR),
    .PRAMWE_N     (PRAMWE_N),
    .PRAM_WR_SIZE (PRAM_WR_SIZE),
    .PRAMDBO_8    (PRAMDBO_8),
    .PRAMDBO_16   (PRAMDBO_16),
    .PRAMDBO_32   (PRAMDBO_32),
    .PRAMDAT_8    (PRAMDAT_8),
    .PRAMDAT_16   (PRAMDAT_16),
    .PRAMDAT_32   (PRAMDAT_32),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .overrun      (overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the visible read-data registers and the sticky error flag.
  logic [31:0] exp_d32;
  logic [15:0] exp_d16;
  logic [7:0]  exp_d8;
  logic        exp_ovr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic we, input logic [1:0] size,
                                          input logic [1:0] lo);
    if (!we || size == 2'd2) return 4'hF;
    if (size == 2'd1) return 4'(3 << (2 * lo[1]));
    return 4'(1 << lo);
  endfunction

  function automatic logic [31:0] model_wdata(input logic we, input logic [1:0] size,
                                              input logic [7:0] d8, input logic [15:0] d16,
                                              input logic [31:0] d32);
    if (!we) return 32'h0;
    if (size == 2'd2) return d32;
    if (size == 2'd1) return 32'(d16) * 32'h0001_0001;
    return 32'(d8) * 32'h0101_0101;
  endfunction

  task automatic model_read(input logic [31:0] rdata, input logic [1:0] lo);
    exp_d32 = rdata;
    exp_d16 = 16'(rdata >> (16 * lo[1]));
    exp_d8  = 8'(rdata >> (8 * lo));
  endtask

  task automatic tick();
    @(posedge CLK21M);
    #1;
  endtask

  task automatic drive_slot(input logic [1:0] ph, input logic we, input logic [1:0] size,
                            input logic [18:0] addr, input logic [7:0] d8,
                            input logic [15:0] d16, input logic [31:0] d32, input int hold);
    DOTSTATE     = ph;
    PRAMWE_N     = ~we;
    PRAM_WR_SIZE = size;
    IRAMADR      = addr;
    PRAMDBO_8    = d8;
    PRAMDBO_16   = d16;
    PRAMDBO_32   = d32;
    repeat (hold) tick();
    DOTSTATE = (ph == 2'b00) ? 2'b01 : 2'b10;
  endtask

  task automatic check_req(input string tag, input logic exp_we, input logic [16:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd);
    check_eq({tag, "/req"},   32'(mem_req),   32'd1);
    check_eq({tag, "/we"},    32'(mem_we),    32'(exp_we));
    check_eq({tag, "/addr"},  32'(mem_addr),  32'(exp_addr));
    check_eq({tag, "/be"},    32'(mem_be),    32'(exp_be));
    check_eq({tag, "/wdata"}, mem_wdata,      exp_wd);
  endtask

  task automatic check_rd(input string tag);
    check_eq({tag, "/d32"}, PRAMDAT_32,      exp_d32);
    check_eq({tag, "/d16"}, 32'(PRAMDAT_16), 32'(exp_d16));
    check_eq({tag, "/d8"},  32'(PRAMDAT_8),  32'(exp_d8));
  endtask

  task automatic ack_pulse();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic rvalid_pulse(input logic [31:0] data);
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    RESET      = 1'b1;
    DOTSTATE   = 2'b01;
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    repeat (2) tick();
    RESET   = 1'b0;
    exp_d32 = 32'h0;
    exp_d16 = 16'h0;
    exp_d8  = 8'h0;
    exp_ovr = 1'b0;
  endtask

  logic [1:0]  r_ph;
  logic        r_we;
  logic [1:0]  r_size;
  logic [18:0] r_addr;
  logic [7:0]  r_d8;
  logic [15:0] r_d16;
  logic [31:0] r_d32;
  logic [31:0] r_rdata;
  int          r_hold;
  int          hi_cnt;

  initial begin
    RESET        = 1'b1;
    DOTSTATE     = 2'b01;
    IRAMADR      = '0;
    PRAMWE_N     = 1'b1;
    PRAM_WR_SIZE = 2'b00;
    PRAMDBO_8    = '0;
    PRAMDBO_16   = '0;
    PRAMDBO_32   = '0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    mem_rvalid   = 1'b0;
    exp_d32 = 32'h0;
    exp_d16 = 16'h0;
    exp_d8  = 8'h0;
    exp_ovr = 1'b0;

    repeat (3) tick();
    check_eq("rst/req",     32'(mem_req),   32'd0);
    check_eq("rst/we",      32'(mem_we),    32'd0);
    check_eq("rst/addr",    32'(mem_addr),  32'd0);
    check_eq("rst/wdata",   mem_wdata,      32'd0);
    check_eq("rst/be",      32'(mem_be),    32'd0);
    check_eq("rst/overrun", 32'(overrun),   32'd0);
    check_rd("rst");
    RESET = 1'b0;
    tick();

    // 8-bit write; request must hold while the live slot inputs move on.
    drive_slot(2'b00, 1'b1, 2'b00, 19'h00001, 8'hA5, 16'h0, 32'h0, 1);
    IRAMADR   = 19'h7ABCD;
    PRAMDBO_8 = 8'h00;
    check_req("wr8", 1'b1, 17'h0, 4'b0010, 32'hA5A5A5A5);
    repeat (3) tick();
    check_req("wr8_hold", 1'b1, 17'h0, 4'b0010, 32'hA5A5A5A5);
    ack_pulse();
    check_eq("wr8_ack/req", 32'(mem_req), 32'd0);
    $display("[TB] txn wr8 addr=00001");

    // 32-bit write then 16-bit read from the same word.
    drive_slot(2'b00, 1'b1, 2'b10, 19'h00008, 8'h0, 16'h0, 32'h11223344, 1);
    check_req("wr32", 1'b1, 17'h2, 4'hF, 32'h11223344);
    ack_pulse();
    check_eq("wr32_ack/req", 32'(mem_req), 32'd0);
    $display("[TB] txn wr32 addr=00008");
    drive_slot(2'b11, 1'b0, 2'b01, 19'h0000A, 8'h0, 16'h0, 32'h0, 1);
    IRAMADR = 19'h7FFFF;
    check_req("rd16", 1'b0, 17'h2, 4'hF, 32'h0);
    check_rd("rd16_pre");
    ack_pulse();
    check_eq("rd16_ack/req", 32'(mem_req), 32'd0);
    tick();
    rvalid_pulse(32'h11223344);
    exp_d32 = 32'h11223344;
    exp_d16 = 16'h1122;
    exp_d8  = 8'h22;
    check_rd("rd16");
    $display("[TB] txn rd16 addr=0000A");

    // Reserved size behaves as a byte write.
    drive_slot(2'b00, 1'b1, 2'b11, 19'h00003, 8'h5A, 16'h0, 32'h0, 1);
    check_req("wr_rsvd", 1'b1, 17'h0, 4'b1000, 32'h5A5A5A5A);
    ack_pulse();
    check_rd("wr_rsvd_keep");
    check_eq("wr_rsvd/overrun", 32'(overrun), 32'd0);
    $display("[TB] txn wr_rsvd addr=00003");

    // Slow ack across the next sample point: second slot dropped.
    drive_slot(2'b00, 1'b1, 2'b00, 19'h00104, 8'h3C, 16'h0, 32'h0, 1);
    tick();
    DOTSTATE = 2'b11;
    PRAMWE_N = 1'b1;
    IRAMADR  = 19'h00200;
    tick();
    DOTSTATE = 2'b10;
    exp_ovr  = 1'b1;
    check_req("drop_hold", 1'b1, 17'h41, 4'b0001, 32'h3C3C3C3C);
    check_eq("drop/overrun", 32'(overrun), 32'(exp_ovr));
    tick();
    tick();
    ack_pulse();
    check_eq("drop_ack/req", 32'(mem_req), 32'd0);
    tick();
    check_eq("drop_noreq", 32'(mem_req), 32'd0);
    $display("[TB] txn drop addr=00104");

    // Reset while waiting for read data; the late data must not land.
    do_reset();
    drive_slot(2'b00, 1'b0, 2'b10, 19'h00010, 8'h0, 16'h0, 32'h0, 1);
    ack_pulse();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
    rvalid_pulse(32'hDEADBEEF);
    check_rd("rst_wait");
    check_eq("rst_wait/req",     32'(mem_req), 32'd0);
    check_eq("rst_wait/overrun", 32'(overrun), 32'd0);
    $display("[TB] txn reset_in_wait addr=00010");

    // Ack never comes: request abandoned after TIMEOUT cycles.
    drive_slot(2'b11, 1'b1, 2'b10, 19'h00020, 8'h0, 16'h0, 32'hCAFEF00D, 1);
    hi_cnt = 0;
    while (mem_req && hi_cnt < 40) begin
      hi_cnt++;
      tick();
    end
    exp_ovr = 1'b1;
    check_eq("tmo/cycles",  32'(hi_cnt),  32'(TIMEOUT));
    check_eq("tmo/overrun", 32'(overrun), 32'(exp_ovr));
    ack_pulse();
    rvalid_pulse(32'h0BADF00D);
    check_eq("tmo_stray/req", 32'(mem_req), 32'd0);
    check_rd("tmo_stray");
    drive_slot(2'b00, 1'b1, 2'b00, 19'h00005, 8'h77, 16'h0, 32'h0, 1);
    check_req("tmo_next", 1'b1, 17'h1, 4'b0010, 32'h77777777);
    ack_pulse();
    $display("[TB] txn timeout addr=00020");

    // Back-to-back reads in slots 00 and 11.
    do_reset();
    DOTSTATE     = 2'b00;
    PRAMWE_N     = 1'b1;
    PRAM_WR_SIZE = 2'b00;
    IRAMADR      = 19'h00401;
    tick();
    check_req("b2b_1", 1'b0, 17'h100, 4'hF, 32'h0);
    DOTSTATE = 2'b01;
    mem_ack  = 1'b1;
    tick();
    mem_ack      = 1'b0;
    DOTSTATE     = 2'b11;
    PRAM_WR_SIZE = 2'b01;
    IRAMADR      = 19'h00803;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'hA1B2C3D4;
    tick();
    mem_rvalid = 1'b0;
    model_read(32'hA1B2C3D4, 2'b01);
    check_rd("b2b_1");
    check_req("b2b_2", 1'b0, 17'h200, 4'hF, 32'h0);
    DOTSTATE = 2'b10;
    mem_ack  = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_eq("b2b_2_ack/req", 32'(mem_req), 32'd0);
    rvalid_pulse(32'h55667788);
    model_read(32'h55667788, 2'b11);
    check_rd("b2b_2");
    check_eq("b2b/overrun", 32'(overrun), 32'd0);
    $display("[TB] txn b2b_reads addr=00401,00803");

    // Randomized slots with random memory latency and occasional stray handshakes.
    for (int t = 0; t < 60; t++) begin
      r_ph    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      r_we    = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_addr  = 19'($urandom);
      r_d8    = 8'($urandom);
      r_d16   = 16'($urandom);
      r_d32   = $urandom;
      r_hold  = int'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        ack_pulse();
        rvalid_pulse($urandom);
        check_rd($sformatf("rnd%0d_stray", t));
      end
      drive_slot(r_ph, r_we, r_size, r_addr, r_d8, r_d16, r_d32, r_hold);
      IRAMADR      = 19'($urandom);
      PRAMWE_N     = 1'($urandom_range(0, 1));
      PRAM_WR_SIZE = 2'($urandom_range(0, 3));
      check_req($sformatf("rnd%0d", t), r_we, r_addr[18:2],
                model_be(r_we, r_size, r_addr[1:0]),
                model_wdata(r_we, r_size, r_d8, r_d16, r_d32));
      repeat ($urandom_range(0, 4)) tick();
      ack_pulse();
      check_eq($sformatf("rnd%0d_ack/req", t), 32'(mem_req), 32'd0);
      if (!r_we) begin
        repeat ($urandom_range(0, 4)) tick();
        r_rdata = $urandom;
        rvalid_pulse(r_rdata);
        model_read(r_rdata, r_addr[1:0]);
      end
      check_rd($sformatf("rnd%0d", t));
      $display("[TB] txn rnd%0d %s size=%0d addr=%05h hold=%0d", t, r_we ? "wr" : "rd",
               r_size, r_addr, r_hold);
    end
    check_eq("rnd/overrun", 32'(overrun), 32'(exp_ovr));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
